// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the dual H-bridge PWM driver: channel state encoding and defaults.
package motor_pwm_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StRamp = 4'b0010,
    StRun  = 4'b0100,
    StDead = 4'b1000
  } ch_state_e;

  localparam int unsigned DefCntW    = 8;
  localparam int unsigned DefPeriod  = 255;
  localparam int unsigned DefDutyMax = 200;
  localparam int unsigned DefStep    = 8;
  localparam int unsigned DefRampDiv = 64;
  localparam int unsigned DefDeadCyc = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_pwm_driver_channel.sv
// One H-bridge channel: soft-start ramp, coast dead-time on reversal, shadowed duty and
// registered PWM legs driven from the shared counter.
module motor_channel
  import motor_pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned DUTY_MAX = DefDutyMax,
  parameter int unsigned STEP     = DefStep,
  parameter int unsigned RAMP_DIV = DefRampDiv,
  parameter int unsigned DEAD_CYC = DefDeadCyc
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic             i_ena_n,
  input  logic             i_dir,
  output logic             o_in1,
  output logic             o_in2,
  output logic             o_run
);

  localparam int unsigned DutyW = CNT_W + 1;
  localparam int unsigned RampW = cnt_width(RAMP_DIV);
  localparam int unsigned DeadW = cnt_width(DEAD_CYC);

  ch_state_e        r_state, w_state_nxt;
  logic [DutyW-1:0] r_duty, w_duty_nxt;
  logic [DutyW-1:0] r_shadow, w_shadow_nxt;
  logic             r_dir, w_dir_nxt;
  logic [RampW-1:0] r_ramp, w_ramp_nxt;
  logic [DeadW-1:0] r_dead, w_dead_nxt;
  logic             r_in1, r_in2, r_run;

  logic [DutyW:0]   w_sum;
  logic [DutyW-1:0] w_ramped;
  logic             w_drive;
  logic             w_on;

  // One extra bit so the saturation test sees the true sum.
  assign w_sum    = {1'b0, r_duty} + (DutyW + 1)'(STEP);
  assign w_ramped = (w_sum >= (DutyW + 1)'(DUTY_MAX)) ? DutyW'(DUTY_MAX) : w_sum[DutyW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_ramp_nxt  = r_ramp;
    w_dead_nxt  = r_dead;
    unique case (r_state)
      StIdle: begin
        w_duty_nxt = '0;
        if (!i_ena_n) begin
          w_dir_nxt   = i_dir;
          w_ramp_nxt  = '0;
          w_state_nxt = StRamp;
        end
      end
      StRamp, StRun: begin
        if (i_ena_n) begin
          w_state_nxt = StIdle;
          w_duty_nxt  = '0;
        end else if (i_dir != r_dir) begin
          w_state_nxt = StDead;
          w_duty_nxt  = '0;
          w_dead_nxt  = '0;
        end else if (r_state == StRamp) begin
          if (r_ramp == RampW'(RAMP_DIV - 1)) begin
            w_ramp_nxt = '0;
            w_duty_nxt = w_ramped;
            if (w_ramped == DutyW'(DUTY_MAX)) begin
              w_state_nxt = StRun;
            end
          end else begin
            w_ramp_nxt = r_ramp + RampW'(1);
          end
        end
      end
      StDead: begin
        w_duty_nxt = '0;
        if (i_ena_n) begin
          w_state_nxt = StIdle;
        end else if (r_dead == DeadW'(DEAD_CYC - 1)) begin
          // Direction is taken only here; toggles during the coast are ignored.
          w_dir_nxt   = i_dir;
          w_ramp_nxt  = '0;
          w_state_nxt = StRamp;
        end else begin
          w_dead_nxt = r_dead + DeadW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_duty_nxt  = '0;
      end
    endcase

    if (w_state_nxt == StIdle || w_state_nxt == StDead) begin
      w_shadow_nxt = '0;
    end else if (i_wrap) begin
      w_shadow_nxt = r_duty;
    end else begin
      w_shadow_nxt = r_shadow;
    end
  end

  // Legs are gated by the next state so IDLE/DEAD entry silences them on the same edge.
  assign w_drive = (w_state_nxt == StRamp) || (w_state_nxt == StRun);
  assign w_on    = w_drive && ({1'b0, i_cnt} < r_shadow);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_duty   <= '0;
      r_shadow <= '0;
      r_dir    <= 1'b0;
      r_ramp   <= '0;
      r_dead   <= '0;
      r_in1    <= 1'b0;
      r_in2    <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_shadow <= w_shadow_nxt;
      r_dir    <= w_dir_nxt;
      r_ramp   <= w_ramp_nxt;
      r_dead   <= w_dead_nxt;
      r_in1    <= w_on & r_dir;
      r_in2    <= w_on & ~r_dir;
      r_run    <= (w_state_nxt == StRun);
    end
  end

  assign o_in1 = r_in1;
  assign o_in2 = r_in2;
  assign o_run = r_run;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver: shared free-running PWM counter feeding two
// independent soft-start / dead-time channels.
module motor_pwm_driver
  import motor_pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned PERIOD   = DefPeriod,
  parameter int unsigned DUTY_MAX = DefDutyMax,
  parameter int unsigned STEP     = DefStep,
  parameter int unsigned RAMP_DIV = DefRampDiv,
  parameter int unsigned DEAD_CYC = DefDeadCyc
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic L_Ena,
  input  logic L_Dir,
  input  logic R_Ena,
  input  logic R_Dir,
  output logic l_in1,
  output logic l_in2,
  output logic r_in1,
  output logic r_in2,
  output logic l_run,
  output logic r_run
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(PERIOD));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  motor_channel #(
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX),
    .STEP     (STEP),
    .RAMP_DIV (RAMP_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_left (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_cnt   (r_cnt),
    .i_wrap  (w_wrap),
    .i_ena_n (L_Ena),
    .i_dir   (L_Dir),
    .o_in1   (l_in1),
    .o_in2   (l_in2),
    .o_run   (l_run)
  );

  motor_channel #(
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX),
    .STEP     (STEP),
    .RAMP_DIV (RAMP_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_right (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_cnt   (r_cnt),
    .i_wrap  (w_wrap),
    .i_ena_n (R_Ena),
    .i_dir   (R_Dir),
    .o_in1   (r_in1),
    .o_in2   (r_in2),
    .o_run   (r_run)
  );

endmodule
